// File: rtl/mem_bus_arbiter.sv
// Two-core shared memory bus arbiter: per-port request capture, round-robin grant, busy backpressure.
// Optional ARB_PERF_COUNTERS_EN adds saturating wait/grant counters with a synchronous clear.

module arb_port #(
    parameter int ADDRW = 24,
    parameter int DATAW = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [ADDRW-1:0] req_addr,
    input  logic [DATAW-1:0] req_wdata,
    input  logic [3:0]       req_wmask,
    input  logic             req_rstrb,
    input  logic             grant,
    input  logic [DATAW-1:0] sh_rdata,
    output logic             pend,
    output logic             lat_wr,
    output logic [ADDRW-1:0] lat_addr,
    output logic [DATAW-1:0] lat_wdata,
    output logic [3:0]       lat_wmask,
    output logic [DATAW-1:0] rdata,
    output logic             rbusy,
    output logic             wbusy,
    output logic             overlap
);
    typedef enum logic [1:0] {IDLE, PEND, RWAIT} state_t;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [DATAW-1:0] wdata;
        logic [3:0]       wmask;
        logic             wr;
    } req_t;

    state_t state, state_next;
    req_t   req_q;
    logic   req_in;
    logic   capture;

    assign req_in = enable && ((req_wmask != 4'b0) || req_rstrb);

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        overlap    = req_in && (state != IDLE);
        case (state)
            IDLE: begin
                if (req_in) begin
                    state_next = PEND;
                    capture    = 1'b1;
                end
            end
            PEND: begin
                // A port disabled while still waiting drops its request outright.
                if (!enable)
                    state_next = IDLE;
                else if (grant)
                    state_next = req_q.wr ? IDLE : RWAIT;
            end
            RWAIT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            req_q <= '0;
            rdata <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                req_q.addr  <= req_addr;
                req_q.wdata <= req_wdata;
                req_q.wmask <= req_wmask;
                req_q.wr    <= (req_wmask != 4'b0);
            end
            if (state == RWAIT)
                rdata <= sh_rdata;
        end
    end

    assign pend      = (state == PEND);
    assign lat_wr    = req_q.wr;
    assign lat_addr  = req_q.addr;
    assign lat_wdata = req_q.wdata;
    assign lat_wmask = req_q.wmask;
    assign rbusy     = (state != IDLE) && !req_q.wr;
    assign wbusy     = (state != IDLE) && req_q.wr;
endmodule

module mem_bus_arbiter #(
    parameter int ADDRW = 24,
    parameter int DATAW = 32
`ifdef ARB_PERF_COUNTERS_EN
    ,
    parameter int CNTW  = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             port1_en,
    input  logic [ADDRW-1:0] c0_addr,
    input  logic [DATAW-1:0] c0_wdata,
    input  logic [3:0]       c0_wmask,
    input  logic             c0_rstrb,
    output logic [DATAW-1:0] c0_rdata,
    output logic             c0_rbusy,
    output logic             c0_wbusy,
    input  logic [ADDRW-1:0] c1_addr,
    input  logic [DATAW-1:0] c1_wdata,
    input  logic [3:0]       c1_wmask,
    input  logic             c1_rstrb,
    output logic [DATAW-1:0] c1_rdata,
    output logic             c1_rbusy,
    output logic             c1_wbusy,
    output logic [ADDRW-1:0] sh_addr,
    output logic [DATAW-1:0] sh_wdata,
    output logic [3:0]       sh_wmask,
    output logic             sh_rstrb,
    output logic             sh_owner,
    input  logic [DATAW-1:0] sh_rdata,
    output logic             err_overlap
`ifdef ARB_PERF_COUNTERS_EN
    ,
    input  logic             clear_cnt,
    output logic [CNTW-1:0]  c0_wait_cnt,
    output logic [CNTW-1:0]  c1_wait_cnt,
    output logic [CNTW-1:0]  grant_cnt
`endif
);
    localparam int NUM_PORTS = 2;

    logic [NUM_PORTS-1:0][ADDRW-1:0] p_addr, lat_addr;
    logic [NUM_PORTS-1:0][DATAW-1:0] p_wdata, lat_wdata, p_rdata;
    logic [NUM_PORTS-1:0][3:0]       p_wmask, lat_wmask;
    logic [NUM_PORTS-1:0]            p_rstrb, port_en, pend, pend_eff, lat_wr;
    logic [NUM_PORTS-1:0]            grant, rbusy, wbusy, overlap;
    logic                            any_grant, gnt_id, last_grant;
    logic [ADDRW-1:0]                addr_q;
    logic [DATAW-1:0]                wdata_q;
    logic                            owner_q;

    assign p_addr  = {c1_addr, c0_addr};
    assign p_wdata = {c1_wdata, c0_wdata};
    assign p_wmask = {c1_wmask, c0_wmask};
    assign p_rstrb = {c1_rstrb, c0_rstrb};
    assign port_en = {port1_en, 1'b1};

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        arb_port #(.ADDRW(ADDRW), .DATAW(DATAW)) u_port (
            .clk       (clk),
            .reset     (reset),
            .enable    (port_en[i]),
            .req_addr  (p_addr[i]),
            .req_wdata (p_wdata[i]),
            .req_wmask (p_wmask[i]),
            .req_rstrb (p_rstrb[i]),
            .grant     (grant[i]),
            .sh_rdata  (sh_rdata),
            .pend      (pend[i]),
            .lat_wr    (lat_wr[i]),
            .lat_addr  (lat_addr[i]),
            .lat_wdata (lat_wdata[i]),
            .lat_wmask (lat_wmask[i]),
            .rdata     (p_rdata[i]),
            .rbusy     (rbusy[i]),
            .wbusy     (wbusy[i]),
            .overlap   (overlap[i])
        );
    end

    // On a tie the port that did not win last time goes first.
    always_comb begin
        pend_eff  = pend & port_en;
        any_grant = |pend_eff;
        gnt_id    = (&pend_eff) ? ~last_grant : pend_eff[1];
        grant     = '0;
        if (any_grant)
            grant[gnt_id] = 1'b1;
    end

    assign sh_addr  = any_grant ? lat_addr[gnt_id]  : addr_q;
    assign sh_wdata = any_grant ? lat_wdata[gnt_id] : wdata_q;
    assign sh_wmask = (any_grant && lat_wr[gnt_id]) ? lat_wmask[gnt_id] : 4'b0;
    assign sh_rstrb = any_grant && !lat_wr[gnt_id];
    assign sh_owner = any_grant ? gnt_id : owner_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant  <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= 1'b0;
            err_overlap <= 1'b0;
        end else begin
            if (any_grant) begin
                last_grant <= gnt_id;
                addr_q     <= lat_addr[gnt_id];
                wdata_q    <= lat_wdata[gnt_id];
                owner_q    <= gnt_id;
            end
            if (|overlap)
                err_overlap <= 1'b1;
        end
    end

    assign c0_rdata = p_rdata[0];
    assign c1_rdata = p_rdata[1];
    assign c0_rbusy = rbusy[0];
    assign c1_rbusy = rbusy[1];
    assign c0_wbusy = wbusy[0];
    assign c1_wbusy = wbusy[1];

`ifdef ARB_PERF_COUNTERS_EN
    logic [NUM_PORTS-1:0][CNTW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            grant_cnt <= '0;
        end else if (clear_cnt) begin
            wait_cnt  <= '0;
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++)
                if (pend_eff[i] && !grant[i] && (wait_cnt[i] != {CNTW{1'b1}}))
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
            if (any_grant && (grant_cnt != {CNTW{1'b1}}))
                grant_cnt <= grant_cnt + 1'b1;
        end
    end

    assign c0_wait_cnt = wait_cnt[0];
    assign c1_wait_cnt = wait_cnt[1];
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: latency, round-robin, overlap, port disable, mid-read reset.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        port1_en;
    logic [23:0] c0_addr, c1_addr, sh_addr;
    logic [31:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata, sh_wdata, sh_rdata;
    logic [3:0]  c0_wmask, c1_wmask, sh_wmask;
    logic        c0_rstrb, c1_rstrb, c0_rbusy, c0_wbusy, c1_rbusy, c1_wbusy;
    logic        sh_rstrb, sh_owner, err_overlap;

    int checks = 0;
    int failures = 0;

    mem_bus_arbiter #(.ADDRW(24), .DATAW(32)) dut (
        .clk(clk), .reset(reset), .port1_en(port1_en),
        .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_wmask(c0_wmask), .c0_rstrb(c0_rstrb),
        .c0_rdata(c0_rdata), .c0_rbusy(c0_rbusy), .c0_wbusy(c0_wbusy),
        .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_wmask(c1_wmask), .c1_rstrb(c1_rstrb),
        .c1_rdata(c1_rdata), .c1_rbusy(c1_rbusy), .c1_wbusy(c1_wbusy),
        .sh_addr(sh_addr), .sh_wdata(sh_wdata), .sh_wmask(sh_wmask), .sh_rstrb(sh_rstrb),
        .sh_owner(sh_owner), .sh_rdata(sh_rdata), .err_overlap(err_overlap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    int prev_owner, alt_bad, grants, run0, run1, max0, max1;

    initial begin
        reset = 1'b1; port1_en = 1'b1; sh_rdata = '0;
        c0_addr = '0; c0_wdata = '0; c0_wmask = '0; c0_rstrb = 1'b0;
        c1_addr = '0; c1_wdata = '0; c1_wmask = '0; c1_rstrb = 1'b0;
        step(); step();
        chk("rst_c0_rbusy", c0_rbusy, 0);
        chk("rst_c0_wbusy", c0_wbusy, 0);
        chk("rst_c1_busy", {c1_rbusy, c1_wbusy}, 0);
        chk("rst_rdata", c0_rdata | c1_rdata, 0);
        chk("rst_sh_wmask", sh_wmask, 0);
        chk("rst_sh_rstrb", sh_rstrb, 0);
        chk("rst_sh_addr", sh_addr, 0);
        chk("rst_sh_owner", sh_owner, 0);
        chk("rst_err", err_overlap, 0);
        reset = 1'b0;
        step();

        // Uncontested c0 write
        c0_addr = 24'h000010; c0_wdata = 32'hDEADBEEF; c0_wmask = 4'hF;
        step();
        chk("wr_sh_wmask", sh_wmask, 4'hF);
        chk("wr_sh_addr", sh_addr, 24'h000010);
        chk("wr_sh_wdata", sh_wdata, 32'hDEADBEEF);
        chk("wr_sh_owner", sh_owner, 0);
        chk("wr_wbusy_hi", c0_wbusy, 1);
        c0_wmask = '0;
        step();
        chk("wr_wbusy_lo", c0_wbusy, 0);
        chk("wr_sh_wmask_off", sh_wmask, 0);
        chk("wr_sh_addr_hold", sh_addr, 24'h000010);

        // Uncontested c0 read
        c0_addr = 24'h010004; c0_rstrb = 1'b1;
        step();
        chk("rd_sh_rstrb", sh_rstrb, 1);
        chk("rd_sh_addr", sh_addr, 24'h010004);
        chk("rd_sh_wmask", sh_wmask, 0);
        chk("rd_rbusy_t1", c0_rbusy, 1);
        c0_rstrb = 1'b0;
        step();
        sh_rdata = 32'h12345678;
        chk("rd_rstrb_once", sh_rstrb, 0);
        chk("rd_rbusy_t2", c0_rbusy, 1);
        step();
        sh_rdata = '0;
        chk("rd_rbusy_t3", c0_rbusy, 0);
        chk("rd_rdata", c0_rdata, 32'h12345678);

        // Tie after reset: c0 first, then c1
        pulse_reset();
        chk("rst2_rdata", c0_rdata, 0);
        c0_addr = 24'h000100; c0_rstrb = 1'b1;
        c1_addr = 24'h000200; c1_rstrb = 1'b1;
        step();
        c0_rstrb = 1'b0; c1_rstrb = 1'b0;
        chk("tie_owner0", sh_owner, 0);
        chk("tie_addr0", sh_addr, 24'h000100);
        chk("tie_c1_rbusy", c1_rbusy, 1);
        step();
        sh_rdata = 32'hAAAA0000;
        chk("tie_owner1", sh_owner, 1);
        chk("tie_addr1", sh_addr, 24'h000200);
        chk("tie_rstrb1", sh_rstrb, 1);
        step();
        sh_rdata = 32'hBBBB1111;
        chk("tie_c0_rbusy", c0_rbusy, 0);
        chk("tie_c0_rdata", c0_rdata, 32'hAAAA0000);
        chk("tie_c1_rbusy_t3", c1_rbusy, 1);
        chk("tie_rstrb_t3", sh_rstrb, 0);
        step();
        sh_rdata = '0;
        chk("tie_c1_rbusy_t4", c1_rbusy, 0);
        chk("tie_c1_rdata", c1_rdata, 32'hBBBB1111);

        // c0 solo write makes c0 the last winner, so the next tie goes to c1
        c0_addr = 24'h000020; c0_wdata = 32'h1; c0_wmask = 4'hF;
        step();
        c0_wmask = '0;
        chk("solo_owner", sh_owner, 0);
        step();
        c0_addr = 24'h000110; c0_rstrb = 1'b1;
        c1_addr = 24'h000210; c1_rstrb = 1'b1;
        step();
        c0_rstrb = 1'b0; c1_rstrb = 1'b0;
        chk("tie2_owner_first", sh_owner, 1);
        chk("tie2_addr_first", sh_addr, 24'h000210);
        step();
        chk("tie2_owner_second", sh_owner, 0);
        chk("tie2_addr_second", sh_addr, 24'h000110);
        step(); step(); step();

        // Back-to-back c0 writes vs c1 reads
        sh_rdata = 32'h5A5A0000;
        prev_owner = -1; alt_bad = 0; grants = 0; run0 = 0; run1 = 0; max0 = 0; max1 = 0;
        c0_wmask = 4'hF; c1_rstrb = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            step();
            if ((sh_wmask != 4'b0) || sh_rstrb) begin
                grants++;
                if (prev_owner == int'(sh_owner)) alt_bad++;
                prev_owner = int'(sh_owner);
            end
            run0 = c0_wbusy ? run0 + 1 : 0;
            run1 = c1_rbusy ? run1 + 1 : 0;
            if (run0 > max0) max0 = run0;
            if (run1 > max1) max1 = run1;
            c0_addr  = 24'h000400 + 24'(cyc);
            c0_wdata = 32'(cyc);
            c0_wmask = c0_wbusy ? 4'h0 : 4'hF;
            c1_addr  = 24'h000800 + 24'(cyc);
            c1_rstrb = !c1_rbusy;
        end
        c0_wmask = '0; c1_rstrb = 1'b0;
        step(); step(); step(); step();
        chk("b2b_alternate", alt_bad, 0);
        chk("b2b_grants_ge10", (grants >= 10) ? 1 : 0, 1);
        chk("b2b_c0_wait", (max0 <= 2) ? 1 : 0, 1);
        chk("b2b_c1_wait", (max1 <= 3) ? 1 : 0, 1);
        chk("b2b_c1_rdata", c1_rdata, 32'h5A5A0000);
        sh_rdata = '0;

        // Overlap: second c1 request while c1 is still pending
        pulse_reset();
        c0_addr = 24'h000040; c0_wdata = 32'h11; c0_wmask = 4'h3;
        c1_addr = 24'h000300; c1_rstrb = 1'b1;
        step();
        c0_wmask = '0;
        c1_addr = 24'h0003FF;
        chk("ovl_owner0", sh_owner, 0);
        chk("ovl_wmask", sh_wmask, 4'h3);
        chk("ovl_err_pre", err_overlap, 0);
        step();
        c1_rstrb = 1'b0;
        chk("ovl_err", err_overlap, 1);
        chk("ovl_owner1", sh_owner, 1);
        chk("ovl_addr_first", sh_addr, 24'h000300);
        step();
        chk("ovl_no_reissue", sh_rstrb, 0);
        step();
        chk("ovl_c1_done", c1_rbusy, 0);
        chk("ovl_no_reissue2", sh_rstrb, 0);

        // port1_en dropped while c1 pending
        c0_addr = 24'h000050; c0_wdata = 32'h22; c0_wmask = 4'hF;
        c1_addr = 24'h000500; c1_rstrb = 1'b1;
        step();
        c0_wmask = '0; c1_rstrb = 1'b0;
        chk("dis_owner0", sh_owner, 0);
        chk("dis_c1_pend", c1_rbusy, 1);
        port1_en = 1'b0;
        step();
        chk("dis_c1_rbusy", c1_rbusy, 0);
        chk("dis_no_rstrb", sh_rstrb, 0);
        chk("dis_no_wmask", sh_wmask, 0);
        c1_rstrb = 1'b1;
        step();
        c1_rstrb = 1'b0;
        chk("dis_ignored", c1_rbusy, 0);
        chk("dis_ignored_bus", sh_rstrb, 0);
        port1_en = 1'b1;
        step();

        // Reset while c0 is in RWAIT
        c0_addr = 24'h000060; c0_rstrb = 1'b1;
        step();
        c0_rstrb = 1'b0;
        step();
        chk("mid_rwait", c0_rbusy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rbusy", c0_rbusy, 0);
        chk("mid_rst_wbusy", c0_wbusy, 0);
        chk("mid_rst_rstrb", sh_rstrb, 0);
        chk("mid_rst_err", err_overlap, 0);
        chk("mid_rst_addr", sh_addr, 0);
        step();
        reset = 1'b0;
        step();
        c0_addr = 24'h000070; c0_rstrb = 1'b1;
        step();
        c0_rstrb = 1'b0;
        chk("post_rstrb", sh_rstrb, 1);
        chk("post_addr", sh_addr, 24'h000070);
        step();
        sh_rdata = 32'hCAFEF00D;
        step();
        sh_rdata = '0;
        chk("post_rbusy", c0_rbusy, 0);
        chk("post_rdata", c0_rdata, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
